// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and helpers for the pwm_fader PWM generator
// Contents:
//   mode_e  - per-channel animation mode (static, triangle, sawtooth, blink)
//   dir_e   - triangle direction (UP, DOWN)
//   cnt_w() - counter width for a 0..n-1 counter, at least one bit
package pwm_pkg;
    typedef enum logic [1:0] {
        MODE_STATIC   = 2'd0,
        MODE_TRIANGLE = 2'd1,
        MODE_SAWTOOTH = 2'd2,
        MODE_BLINK    = 2'd3
    } mode_e;
    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_e;
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM lane - shadow mode, brightness FSM, latched duty and registered compare
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   i_enable      - global run; low clears brightness, duty and output
//   i_bound       - period boundary strobe (cnt restarting at 0)
//   i_step        - brightness step strobe, only ever asserted together with i_bound
//   i_cnt         - shared PWM counter
//   i_mode        - requested mode, sampled at the boundary
//   i_level       - static duty or animated peak, sampled at the boundary
//   o_pwm         - registered PWM output
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_enable,
    input  logic                i_bound,
    input  logic                i_step,
    input  logic [PWM_BITS-1:0] i_cnt,
    input  logic [1:0]          i_mode,
    input  logic [PWM_BITS-1:0] i_level,
    output logic                o_pwm
);
    mode_e               r_mode;
    mode_e               w_mode;
    dir_e                r_dir;
    dir_e                w_dir0;
    dir_e                w_dir_nxt;
    logic [PWM_BITS-1:0] r_b;
    logic [PWM_BITS-1:0] r_duty;
    logic [PWM_BITS-1:0] w_b0;
    logic [PWM_BITS-1:0] w_b_nxt;
    logic [PWM_BITS-1:0] w_duty_nxt;
    logic                r_pwm;

    assign w_mode = mode_e'(i_mode);
    assign o_pwm  = r_pwm;

    // w_b0/w_dir0 is the pre-step state: a mode change, static mode or a zero
    // peak restarts the animation from 0/UP. The boundary latches this pre-step
    // value as duty, so a step shows up one period later.
    always_comb begin
        w_b0       = r_b;
        w_dir0     = r_dir;
        if (w_mode != r_mode || w_mode == MODE_STATIC || i_level == '0) begin
            w_b0   = '0;
            w_dir0 = UP;
        end
        w_b_nxt    = r_b;
        w_dir_nxt  = r_dir;
        w_duty_nxt = r_duty;
        if (i_bound) begin
            w_duty_nxt = (w_mode == MODE_STATIC) ? i_level : w_b0;
            w_b_nxt    = w_b0;
            w_dir_nxt  = w_dir0;
            if (i_step && w_mode != MODE_STATIC && i_level != '0) begin
                case (w_mode)
                    MODE_TRIANGLE: begin
                        if (w_b0 > i_level) begin
                            w_b_nxt   = i_level;
                            w_dir_nxt = DOWN;
                        end else if (w_dir0 == UP) begin
                            w_dir_nxt = (w_b0 == i_level) ? DOWN : UP;
                            w_b_nxt   = (w_b0 == i_level) ? w_b0 - 1'b1 : w_b0 + 1'b1;
                        end else begin
                            w_dir_nxt = (w_b0 == '0) ? UP : DOWN;
                            w_b_nxt   = (w_b0 == '0) ? w_b0 + 1'b1 : w_b0 - 1'b1;
                        end
                    end
                    MODE_SAWTOOTH: w_b_nxt = (w_b0 >= i_level) ? '0 : w_b0 + 1'b1;
                    default:       w_b_nxt = (w_b0 == '0) ? i_level : '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= MODE_STATIC;
            r_dir  <= UP;
            r_b    <= '0;
            r_duty <= '0;
            r_pwm  <= 1'b0;
        end else if (!i_enable) begin
            r_mode <= MODE_STATIC;
            r_dir  <= UP;
            r_b    <= '0;
            r_duty <= '0;
            r_pwm  <= 1'b0;
        end else begin
            if (i_bound)
                r_mode <= w_mode;
            r_dir  <= w_dir_nxt;
            r_b    <= w_b_nxt;
            r_duty <= w_duty_nxt;
            r_pwm  <= (i_cnt < r_duty);
        end
    end
endmodule

// File: rtl/pwm_fader.sv
// pwm_fader: multi-channel PWM generator with static, triangle, sawtooth and blink modes
// Ports:
//   clk          - system clock
//   rst_n        - asynchronous active-low reset
//   enable       - global run; low clears counters and forces outputs low
//   mode         - 2 bits per channel, channel i at [2i+1:2i]
//   level        - PWM_BITS per channel, duty (static) or peak (animated)
//   pwm_out      - one registered PWM line per channel
//   period_start - one-cycle pulse on the first tick of each PWM period
module pwm_fader
    import pwm_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 16,
    parameter int STEP_DIV = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic [2*CHANNELS-1:0]        mode,
    input  logic [PWM_BITS*CHANNELS-1:0] level,
    output logic [CHANNELS-1:0]          pwm_out,
    output logic                         period_start
);
    localparam int PW = cnt_w(PRESCALE);
    localparam int SW = cnt_w(STEP_DIV);

    logic [PW-1:0]       r_pre;
    logic [PWM_BITS-1:0] r_cnt;
    logic [SW-1:0]       r_stepc;
    logic                r_run;
    logic                r_ps;
    logic                w_tick;
    logic                w_bound;
    logic                w_step;

    // The first tick after reset/enable opens a period with cnt held at 0,
    // so the first boundary lands PRESCALE clocks after restart.
    assign w_tick       = enable && (r_pre == PW'(PRESCALE - 1));
    assign w_bound      = w_tick && (!r_run || (&r_cnt));
    assign w_step       = w_bound && (r_stepc == SW'(STEP_DIV - 1));
    assign period_start = r_ps;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre   <= '0;
            r_cnt   <= '0;
            r_stepc <= '0;
            r_run   <= 1'b0;
            r_ps    <= 1'b0;
        end else if (!enable) begin
            r_pre   <= '0;
            r_cnt   <= '0;
            r_stepc <= '0;
            r_run   <= 1'b0;
            r_ps    <= 1'b0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick) begin
                r_run <= 1'b1;
                if (r_run)
                    r_cnt <= r_cnt + 1'b1;
            end
            if (w_bound)
                r_stepc <= w_step ? '0 : r_stepc + 1'b1;
            r_ps <= w_bound;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_channel #(
            .PWM_BITS(PWM_BITS)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_enable(enable),
            .i_bound (w_bound),
            .i_step  (w_step),
            .i_cnt   (r_cnt),
            .i_mode  (mode[2*i +: 2]),
            .i_level (level[PWM_BITS*i +: PWM_BITS]),
            .o_pwm   (pwm_out[i])
        );
    end
endmodule
